pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle processor, replacing the plain `next_pc`-latching counter. It owns the PC register and computes the next PC internally: sequential, PC-relative branch, absolute jump and register jump. It adds a stall hold, a configurable reset vector and a small return-address stack (RAS) that predicts `jr $ra` targets. It sits between the control unit/ALU (branch decision, register operand) and instruction memory (fetch address).

## Interface
Parameters:
- `WIDTH`, 32: PC and address width in bits (minimum `JUMP_BITS+4`).
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset.
- `JUMP_BITS`, 26: width of the absolute jump index field.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, at least 2).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `stall`, in, 1: hold the PC and RAS this cycle.
- `mode`, in, 2: next-PC source; 00 SEQ, 01 BRANCH, 10 JUMP, 11 JREG.
- `branch_taken`, in, 1: condition result, used only in BRANCH mode.
- `branch_offset`, in, 16: signed word offset.
- `jump_index`, in, `JUMP_BITS`: absolute jump index.
- `reg_target`, in, `WIDTH`: register operand for JREG.
- `call`, in, 1: link; push `pc_plus4` (valid with JUMP or JREG).
- `ret`, in, 1: return; pop the RAS (valid with JREG).
- `pc`, out, `WIDTH`: current fetch address, registered.
- `pc_plus4`, out, `WIDTH`: `pc + 4`, combinational.
- `ras_empty`, out, 1: the RAS holds 0 entries.
- `ras_full`, out, 1: the RAS holds `RAS_DEPTH` entries.
- `misaligned`, out, 1: registered; the last loaded target had nonzero bits [1:0].

## Operation
- Next-PC selection:
  - SEQ: `pc_plus4`.
  - BRANCH: `pc_plus4 + (sign_extend(branch_offset) << 2)` if `branch_taken`, else `pc_plus4`.
  - JUMP: `{pc_plus4[WIDTH-1:JUMP_BITS+2], jump_index, 2'b00}`.
  - JREG with `ret` and RAS non-empty: RAS top. Otherwise JREG uses `reg_target`.
- Low two bits of every loaded PC are forced to 0. When the selected source had nonzero low bits, `misaligned` is set for that cycle.
- All arithmetic is modulo 2^`WIDTH`. `pc_plus4` and branch targets wrap silently.
- RAS behaviour:
  - It is a circular buffer with a top pointer and a count.
  - Push writes `pc_plus4` above top; count saturates at `RAS_DEPTH`.
  - Push when full overwrites the oldest entry; `ras_full` stays 1.
  - Pop decrements top and count.
  - Pop when empty: no state change, and the target falls back to `reg_target`.
  - `call` and `ret` in the same cycle: the top entry is replaced by `pc_plus4` and count is unchanged. The prediction uses the old top.
  - `call` or `ret` outside their legal modes is ignored.
- `stall`=1: `pc`, `misaligned` and RAS are unchanged, and all mode inputs are ignored.
- Reset puts the block in its reset state:
  - `pc`=`RESET_VECTOR`, RAS count 0 and top 0, `misaligned`=0.
  - Therefore `ras_empty`=1 and `ras_full`=0.
  - Reset overrides `stall` and any mode.

## Timing
- Every state change happens on the rising `clk` edge. `pc` reflects the selection one cycle after its inputs are presented, with zero extra latency.
- `pc_plus4` follows `pc` combinationally within the same cycle.
- `ras_empty`/`ras_full` are decoded from registered count and change in the cycle after a push or pop.
- Reset asserted mid-stream is taken on the next edge and discards any push/pop presented in that cycle.
- Reset deasserted: the first fetch address is `RESET_VECTOR`. The first update happens on the following edge.

## Structure
- Shared package `pc_pkg` holds:
  - mode localparams `PC_SEQ`, `PC_BRANCH`, `PC_JUMP`, `PC_JREG`;
  - the word-step constant 4;
  - a default `RESET_VECTOR`.
- Sub-module `return_stack` (params `WIDTH`, `RAS_DEPTH`; ports `clk`, `reset`, `en`, `push`, `pop`, `push_data`, `top`, `empty`, `full`).
- `pc_unit` holds the next-PC mux, the adders and the PC register.

## Test plan
- Reset with `RESET_VECTOR`=32'h0040_0000, then 3 SEQ cycles: `pc` = 0x400000, 0x400004, 0x400008, 0x40000C; `ras_empty`=1.
- BRANCH at `pc`=0x100 with offset 16'hFFFE: taken gives 0xFC; not taken gives 0x104. JUMP with `jump_index`=26'h0000040 gives 0x100.
- `stall` held 2 cycles during JUMP: `pc` frozen. Then `stall`=0 and reset on the same edge: `pc`=`RESET_VECTOR`.
- RAS, `RAS_DEPTH`=4:
  - 5 calls at `pc_plus4` 0x10, 0x20, 0x30, 0x40, 0x50: `ras_full`=1.
  - 4 rets return 0x50, 0x40, 0x30, 0x20; `ras_empty`=1.
  - A 5th ret goes to `reg_target`=0x900.
- Simultaneous `call`+`ret` with top=0x80 at `pc`=0x200: next `pc`=0x80, new top=0x204, count unchanged.
- JREG with `reg_target`=0x1003: `pc`=0x1000 and `misaligned`=1. Next SEQ cycle: `misaligned`=0. Wrap case: `pc`=0xFFFF_FFFC then SEQ gives 0x0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source codes,
// the word step and the default reset vector.
package pc_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JREG   = 2'b11;

  localparam int unsigned WORD_STEP = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // A fetch target is misaligned when either byte-offset bit is set.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating count; a push when full
// overwrites the oldest entry, and a pop when empty leaves the state alone.
module return_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] above_s;
  logic             has_entry_s;

  assign above_s     = top_r + PTR_ONE;
  assign has_entry_s = (count_r != CNT_ZERO);

  // Stack storage, top pointer and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_r   <= {PTR_W{1'b0}};
      count_r <= CNT_ZERO;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (en) begin
      // Call+return together swaps the top entry in place.
      if (push && pop && has_entry_s) begin
        mem_r[top_r] <= push_data;
      end else if (push) begin
        mem_r[above_s] <= push_data;
        top_r          <= above_s;
        if (count_r != DEPTH_C) begin
          count_r <= count_r + CNT_ONE;
        end
      end else if (pop && has_entry_s) begin
        top_r   <= top_r - PTR_ONE;
        count_r <= count_r - CNT_ONE;
      end
    end
  end

  assign top   = mem_r[top_r];
  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == DEPTH_C);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (sequential, branch, jump, register
// jump), stall hold, reset vector and return-address prediction for jr $ra.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               JUMP_BITS    = 26,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           mode,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_offset,
  input  logic [JUMP_BITS-1:0] jump_index,
  input  logic [WIDTH-1:0]     reg_target,
  input  logic                 call,
  input  logic                 ret,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 misaligned
);

  logic [WIDTH-1:0] pc_r;
  logic             misaligned_r;
  logic [WIDTH-1:0] pc_plus4_s;
  logic [WIDTH-1:0] branch_disp_s;
  logic [WIDTH-1:0] jump_target_s;
  logic [WIDTH-1:0] ras_top_s;
  logic [WIDTH-1:0] next_raw_s;
  logic             push_s;
  logic             pop_s;

  assign pc_plus4_s    = pc_r + WIDTH'(WORD_STEP);
  assign branch_disp_s = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target_s = {pc_plus4_s[WIDTH-1:JUMP_BITS+2], jump_index, 2'b00};

  // Link/return requests are honoured only in the modes that can carry them.
  assign push_s = call && ((mode == PC_JUMP) || (mode == PC_JREG));
  assign pop_s  = ret && (mode == PC_JREG);

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .en        (~stall),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus4_s),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-PC source selection before alignment.
  always_comb begin
    next_raw_s = pc_plus4_s;
    case (mode)
      PC_SEQ: begin
        next_raw_s = pc_plus4_s;
      end
      PC_BRANCH: begin
        if (branch_taken) begin
          next_raw_s = pc_plus4_s + branch_disp_s;
        end else begin
          next_raw_s = pc_plus4_s;
        end
      end
      PC_JUMP: begin
        next_raw_s = jump_target_s;
      end
      PC_JREG: begin
        if (pop_s && !ras_empty) begin
          next_raw_s = ras_top_s;
        end else begin
          next_raw_s = reg_target;
        end
      end
      default: begin
        next_raw_s = pc_plus4_s;
      end
    endcase
  end

  // PC register and misalignment flag, frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_VECTOR;
      misaligned_r <= 1'b0;
    end else if (!stall) begin
      pc_r         <= {next_raw_s[WIDTH-1:2], 2'b00};
      misaligned_r <= word_misaligned(next_raw_s[1:0]);
    end
  end

  assign pc         = pc_r;
  assign pc_plus4   = pc_plus4_s;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0000;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] reg_target = 32'h0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        misaligned;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .JUMP_BITS    (26),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .mode          (mode),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] m, input logic [31:0] tgt, input logic c, input logic r);
    mode       = m;
    reg_target = tgt;
    call       = c;
    ret        = r;
  endtask

  initial begin
    // Reset and sequential fetch
    reset = 1'b1;
    step();
    check("reset_pc", pc, RV);
    check("reset_empty", 32'(ras_empty), 32'd1);
    check("reset_full", 32'(ras_full), 32'd0);
    check("reset_mis", 32'(misaligned), 32'd0);
    reset = 1'b0;
    set_in(2'b00, 32'h0, 1'b0, 1'b0);
    check("first_fetch", pc, 32'h0040_0000);
    check("first_plus4", pc_plus4, 32'h0040_0004);
    step();
    check("seq1", pc, 32'h0040_0004);
    step();
    check("seq2", pc, 32'h0040_0008);
    step();
    check("seq3", pc, 32'h0040_000C);
    check("seq_empty", 32'(ras_empty), 32'd1);

    // Branch taken / not taken, absolute jump
    set_in(2'b11, 32'h0000_0100, 1'b0, 1'b0);
    step();
    check("jreg_100", pc, 32'h0000_0100);
    mode = 2'b01; branch_taken = 1'b1; branch_offset = 16'hFFFE;
    step();
    check("br_taken", pc, 32'h0000_00FC);
    set_in(2'b11, 32'h0000_0100, 1'b0, 1'b0);
    step();
    mode = 2'b01; branch_taken = 1'b0;
    step();
    check("br_not_taken", pc, 32'h0000_0104);
    mode = 2'b10; jump_index = 26'h0000040;
    step();
    check("jump", pc, 32'h0000_0100);

    // Stall during a jump, then reset on the release edge
    set_in(2'b11, 32'h0000_0200, 1'b0, 1'b0);
    step();
    mode = 2'b10; jump_index = 26'h0000050; stall = 1'b1;
    step();
    check("stall1", pc, 32'h0000_0200);
    step();
    check("stall2", pc, 32'h0000_0200);
    stall = 1'b0; reset = 1'b1;
    step();
    check("stall_reset", pc, RV);
    reset = 1'b0;

    // Call outside a legal mode is ignored
    set_in(2'b00, 32'h0, 1'b1, 1'b0);
    step();
    check("call_seq_ignored", 32'(ras_empty), 32'd1);

    // Fill the RAS past its depth
    set_in(2'b11, 32'h0000_000C, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 5; i++) begin
      set_in(2'b11, 32'(i * 16 + 12), 1'b1, 1'b0);
      step();
      if (i == 4) check("full_after4", 32'(ras_full), 32'd1);
    end
    check("full_after5", 32'(ras_full), 32'd1);
    check("pc_after_calls", pc, 32'h0000_005C);

    // Four returns pop newest first; oldest (0x10) was overwritten
    set_in(2'b11, 32'h0000_0900, 1'b0, 1'b1);
    step();
    check("ret1", pc, 32'h0000_0050);
    check("ret1_notfull", 32'(ras_full), 32'd0);
    step();
    check("ret2", pc, 32'h0000_0040);
    step();
    check("ret3", pc, 32'h0000_0030);
    step();
    check("ret4", pc, 32'h0000_0020);
    check("ret4_empty", 32'(ras_empty), 32'd1);
    step();
    check("ret5_fallback", pc, 32'h0000_0900);
    check("ret5_empty", 32'(ras_empty), 32'd1);

    // Simultaneous call+ret replaces the top entry
    set_in(2'b11, 32'h0000_007C, 1'b0, 1'b0);
    step();
    set_in(2'b11, 32'h0000_0200, 1'b1, 1'b0);
    step();
    check("push80_pc", pc, 32'h0000_0200);
    set_in(2'b11, 32'h0000_0900, 1'b1, 1'b1);
    step();
    check("callret_pc", pc, 32'h0000_0080);
    check("callret_notempty", 32'(ras_empty), 32'd0);
    check("callret_notfull", 32'(ras_full), 32'd0);
    set_in(2'b11, 32'h0000_0900, 1'b0, 1'b1);
    step();
    check("callret_newtop", pc, 32'h0000_0204);
    check("callret_count1", 32'(ras_empty), 32'd1);

    // Reset discards a push presented on the same edge
    set_in(2'b11, 32'h0000_0300, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    check("reset_push_empty", 32'(ras_empty), 32'd1);
    check("reset_push_pc", pc, RV);
    reset = 1'b0;

    // Misaligned register target and wrap-around
    set_in(2'b11, 32'h0000_1003, 1'b0, 1'b0);
    step();
    check("mis_pc", pc, 32'h0000_1000);
    check("mis_set", 32'(misaligned), 32'd1);
    set_in(2'b00, 32'h0, 1'b0, 1'b0);
    step();
    check("mis_seq_pc", pc, 32'h0000_1004);
    check("mis_clear", 32'(misaligned), 32'd0);
    set_in(2'b11, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    set_in(2'b00, 32'h0, 1'b0, 1'b0);
    step();
    check("wrap_seq", pc, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
